// File: rtl/dst_readback_packer.sv
// Walks the destination image buffer after a downscale, packs 4 pixels per
// 32-bit word into a small FIFO and serves one word per consumer read request.
module dst_readback_packer #(
  parameter int DST_W      = 256,
  parameter int DST_H      = 256,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  input  logic              rd_req,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              underflow,
  output logic [ADDR_W-1:0] words_left
);
  localparam int NPIX = DST_W * DST_H;
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] WORDS_INIT = ADDR_W'(NPIX / 4);
  localparam logic [PW:0]       DEPTH_C    = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          sub_q, sub_d;
  logic                open_q, open_d;
  logic                ret_vld_q, ret_vld_d;
  logic                ret_last_q, ret_last_d;
  logic [23:0]         pack_q, pack_d;
  logic [31:0]         fifo_q [FIFO_DEPTH];
  logic [31:0]         fifo_d [FIFO_DEPTH];
  logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]         cnt_q, cnt_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                underflow_q, underflow_d;
  logic [ADDR_W-1:0]   words_left_q, words_left_d;
  logic [PW:0]         slots;
  logic                issue, push, pop;

  // A word that has started reading holds a slot until it lands in the FIFO,
  // so the FIFO can never be asked to take more than it has room for.
  assign slots = cnt_q + (PW + 1)'(open_q);
  assign issue = (state_q == FETCH) && ((sub_q != 2'd0) || (slots < DEPTH_C));
  assign push  = ret_vld_q && ret_last_q;
  assign pop   = rd_req && (cnt_q != '0);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    sub_d        = sub_q;
    open_d       = open_q;
    ret_vld_d    = 1'b0;
    ret_last_d   = 1'b0;
    pack_d       = pack_q;
    fifo_d       = fifo_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    busy_d       = busy_q;
    done_d       = done_q;
    underflow_d  = underflow_q;
    words_left_d = words_left_q;

    if (ret_vld_q) pack_d = {mem_rd_data, pack_q[23:8]};
    if (push) begin
      fifo_d[wptr_q] = {mem_rd_data, pack_q};
      wptr_d         = wptr_q + PW'(1);
      open_d         = 1'b0;
    end
    if (pop) begin
      rd_data_d    = fifo_q[rptr_q];
      rptr_d       = rptr_q + PW'(1);
      rd_valid_d   = 1'b1;
      words_left_d = words_left_q - ADDR_W'(1);
    end
    if (rd_req && (cnt_q == '0)) underflow_d = 1'b1;
    cnt_d = cnt_q + (PW + 1)'(push) - (PW + 1)'(pop);

    if (issue) begin
      ret_vld_d  = 1'b1;
      ret_last_d = (sub_q == 2'd3);
      sub_d      = sub_q + 2'd1;
      addr_d     = addr_q + ADDR_W'(1);
      if (sub_q == 2'd0) open_d = 1'b1;
    end

    case (state_q)
      IDLE: if (start) begin
        state_d      = FETCH;
        done_d       = 1'b0;
        underflow_d  = 1'b0;
        words_left_d = WORDS_INIT;
        addr_d       = '0;
        sub_d        = 2'd0;
        busy_d       = 1'b1;
      end
      FETCH: if (issue && (addr_q == LAST_ADDR)) state_d = DRAIN;
      DRAIN: if (!open_q && (cnt_q == '0)) begin
        state_d = FIN;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      sub_q        <= 2'd0;
      open_q       <= 1'b0;
      ret_vld_q    <= 1'b0;
      ret_last_q   <= 1'b0;
      pack_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underflow_q  <= 1'b0;
      words_left_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      sub_q        <= sub_d;
      open_q       <= open_d;
      ret_vld_q    <= ret_vld_d;
      ret_last_q   <= ret_last_d;
      pack_q       <= pack_d;
      fifo_q       <= fifo_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      underflow_q  <= underflow_d;
      words_left_q <= words_left_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (cnt_q == DEPTH_C)));

  assign mem_rd_en  = issue;
  assign mem_addr   = addr_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign underflow  = underflow_q;
  assign words_left = words_left_q;
endmodule
